// File: rtl/mem_lsu.sv
// Load/store initiator for a single-port 128x32 data RAM.
// Performs byte/halfword/word loads and stores, with a read-modify-write
// sequence for sub-word stores. Loads return extended data, and every
// request ends with a one-cycle done pulse carrying an error flag.
// R_data is the RAM's combinational read data for the registered Addr.
module mem_lsu #(
    parameter int AW         = 7,
    parameter bit BASE_CHECK = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    input  logic [31:0]   R_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   rdata,
    output logic [AW-1:0] Addr,
    output logic          W,
    output logic          R,
    output logic [31:0]   W_data
);

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, FIN} state_t;

    state_t        state_q, state_d;
    logic [1:0]    size_q, size_d;
    logic [1:0]    off_q, off_d;
    logic          uns_q, uns_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          w_q, w_d;
    logic          r_q, r_d;

    logic          req_err;
    logic [4:0]    lane_sh;
    logic [31:0]   ld_shift, ld_ext, lane_mask, st_shift;

    // Decode request legality: reserved size, misalignment, out-of-range address
    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b11:   req_err = 1'b1;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            default: req_err = 1'b0;
        endcase
        if (BASE_CHECK && (|req_addr[31:AW+2]))
            req_err = 1'b1;
    end

    // Lane alignment: extract/extend for loads, mask and shift for sub-word stores
    always_comb begin
        lane_sh   = {off_q, 3'b000};
        ld_shift  = R_data >> lane_sh;
        lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_sh;
        st_shift  = wdata_q << lane_sh;
        case (size_q)
            2'b00:   ld_ext = uns_q ? {24'h0, ld_shift[7:0]}
                                    : {{24{ld_shift[7]}}, ld_shift[7:0]};
            2'b01:   ld_ext = uns_q ? {16'h0, ld_shift[15:0]}
                                    : {{16{ld_shift[15]}}, ld_shift[15:0]};
            default: ld_ext = R_data;
        endcase
    end

    // Next-state logic; registered outputs are derived from the next state
    // so W/R/busy/done line up exactly with the state they describe
    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        off_d   = off_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr[AW+1:2];
                    off_d   = req_addr[1:0];
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    err_d   = req_err;
                    rdata_d = 32'h0;
                    if (req_err)                state_d = FIN;
                    else if (!req_we)           state_d = RD;
                    else if (req_size == 2'b10) state_d = WR;
                    else                        state_d = RMW_RD;
                end
            end
            RD: begin
                rdata_d = ld_ext;
                state_d = FIN;
            end
            RMW_RD: begin
                // Merged word is parked in W_data before W rises
                wdata_d = (R_data & ~lane_mask) | (st_shift & lane_mask);
                state_d = WR;
            end
            WR:      state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RD) || (state_d == RMW_RD) || (state_d == WR);
        done_d = (state_d == FIN);
        w_d    = (state_d == WR);
        r_d    = (state_d == RD) || (state_d == RMW_RD);
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            w_q     <= 1'b0;
            r_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            off_q   <= off_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            w_q     <= w_d;
            r_q     <= r_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign rdata  = rdata_q;
    assign Addr   = addr_q;
    assign W      = w_q;
    assign R      = r_q;
    assign W_data = wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: requests push expected completions into a
// queue, a negedge monitor pops and checks them on every done pulse.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic [31:0] R_data;
    logic        busy, done, err, W, R;
    logic [31:0] rdata, W_data;
    logic [6:0]  Addr;

    always #5 clk = ~clk;

    mem_lsu #(.AW(7), .BASE_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .R_data(R_data), .busy(busy), .done(done),
        .err(err), .rdata(rdata), .Addr(Addr), .W(W), .R(R), .W_data(W_data)
    );

    // RAM model: level-sensitive write, combinational read
    logic [31:0] mem [128];
    always @(posedge clk) if (W) mem[Addr] <= W_data;
    assign R_data = mem[Addr];

    typedef struct {
        string       nm;
        logic        err;
        logic        chk_rd;
        logic [31:0] rd;
        logic [31:0] alt;
        int          lat;
        int          ref_kind;   // 0: latency from issue, 1: from previous done
        int          wcnt;
        int          issue_cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0, fails = 0;
    int   cyc = 0, last_done = 0, wcnt = 0;
    bit   outstanding = 0, prev_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
        end
    endtask

    function automatic exp_t mk(input string nm, input logic e, input logic c,
                                input logic [31:0] rd, input logic [31:0] alt,
                                input int lat, input int wc);
        exp_t x;
        x.nm = nm; x.err = e; x.chk_rd = c; x.rd = rd; x.alt = alt;
        x.lat = lat; x.ref_kind = 0; x.wcnt = wc; x.issue_cyc = 0;
        return x;
    endfunction

    // Monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        if (rst) begin
            wcnt = 0;
            prev_done = 0;
        end else begin
            if (W) wcnt++;
            if (done) begin
                chk("done_not_back_to_back", {31'h0, prev_done}, 32'h0);
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    int   lat;
                    e = q.pop_front();
                    lat = (e.ref_kind == 0) ? (cyc - e.issue_cyc) : (cyc - last_done);
                    chk({e.nm, "_err"}, {31'h0, err}, {31'h0, e.err});
                    chk({e.nm, "_lat"}, lat, e.lat);
                    chk({e.nm, "_wcnt"}, wcnt, e.wcnt);
                    if (e.chk_rd)
                        chk({e.nm, "_rdata"}, (rdata === e.alt) ? e.rd : rdata, e.rd);
                end
                outstanding = 0;
                wcnt = 0;
                last_done = cyc;
            end
            prev_done = done;
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((outstanding || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'h1, 32'h0);
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input exp_t e);
        wait_idle();
        req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        e.issue_cyc = cyc;
        q.push_back(e);
        outstanding = 1;
        @(negedge clk);
        req_valid = 0; req_we = 1; req_addr = 32'h0000_0010; req_wdata = 32'hFFFF_FFFF;
    endtask

    initial begin
        exp_t e;
        int   n;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_W", {31'h0, W}, 32'h0);
        chk("rst_R", {31'h0, R}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_Addr", {25'h0, Addr}, 32'h0);
        chk("rst_W_data", W_data, 32'h0);
        rst = 0;

        // Word store / load
        issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, mk("sw10", 0, 0, 0, 0, 2, 1));
        issue(0, 2'b10, 0, 32'h10, 32'h0, mk("lw10", 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 2, 0));
        // Byte RMW
        issue(1, 2'b10, 0, 32'h20, 32'h11223344, mk("sw20", 0, 0, 0, 0, 2, 1));
        issue(1, 2'b00, 0, 32'h22, 32'h000000AA, mk("sb22", 0, 0, 0, 0, 3, 1));
        issue(0, 2'b10, 0, 32'h20, 32'h0, mk("lw20", 0, 1, 32'h11AA3344, 32'h11AA3344, 2, 0));
        issue(0, 2'b00, 0, 32'h22, 32'h0, mk("lb22", 0, 1, 32'hFFFFFFAA, 32'hFFFFFFAA, 2, 0));
        issue(0, 2'b00, 1, 32'h22, 32'h0, mk("lbu22", 0, 1, 32'h000000AA, 32'h000000AA, 2, 0));
        // Halfword RMW in upper lane
        issue(1, 2'b10, 0, 32'h24, 32'h11AA3344, mk("sw24", 0, 0, 0, 0, 2, 1));
        issue(1, 2'b01, 0, 32'h26, 32'h00008001, mk("sh26", 0, 0, 0, 0, 3, 1));
        issue(0, 2'b10, 0, 32'h24, 32'h0, mk("lw24", 0, 1, 32'h80013344, 32'h80013344, 2, 0));
        issue(0, 2'b01, 0, 32'h26, 32'h0, mk("lh26", 0, 1, 32'hFFFF8001, 32'hFFFF8001, 2, 0));
        issue(0, 2'b01, 1, 32'h26, 32'h0, mk("lhu26", 0, 1, 32'h00008001, 32'h00008001, 2, 0));
        issue(0, 2'b01, 0, 32'h24, 32'h0, mk("lh24", 0, 1, 32'h00003344, 32'h00003344, 2, 0));
        issue(0, 2'b00, 0, 32'h27, 32'h0, mk("lb27", 0, 1, 32'hFFFFFF80, 32'hFFFFFF80, 2, 0));
        issue(0, 2'b00, 1, 32'h24, 32'h0, mk("lbu24", 0, 1, 32'h00000044, 32'h00000044, 2, 0));
        // Error requests
        issue(0, 2'b10, 0, 32'h21, 32'h0, mk("lw21_err", 1, 1, 0, 0, 1, 0));
        issue(0, 2'b01, 0, 32'h23, 32'h0, mk("lh23_err", 1, 1, 0, 0, 1, 0));
        issue(0, 2'b11, 0, 32'h20, 32'h0, mk("size11_err", 1, 1, 0, 0, 1, 0));
        issue(1, 2'b10, 0, 32'h200, 32'h12345678, mk("sw200_err", 1, 1, 0, 0, 1, 0));
        issue(1, 2'b01, 0, 32'h25, 32'h00001234, mk("sh25_err", 1, 1, 0, 0, 1, 0));
        issue(0, 2'b10, 0, 32'h24, 32'h0, mk("lw24_after_err", 0, 1, 32'h80013344, 32'h80013344, 2, 0));

        // req_valid held high: changes while busy are ignored, next one taken after done
        wait_idle();
        req_valid = 1; req_we = 0; req_size = 2'b10; req_unsigned = 0;
        req_addr = 32'h10; req_wdata = 32'h0;
        e = mk("b2b_a", 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 2, 0);
        e.issue_cyc = cyc;
        q.push_back(e);
        outstanding = 1;
        @(negedge clk);
        chk("b2b_busy_in_rd", {31'h0, busy}, 32'h1);
        req_we = 1; req_addr = 32'h10; req_wdata = 32'h0BAD0BAD;   // must be ignored
        n = 0;
        while (!done && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("b2b_timeout", 32'h1, 32'h0);
        req_we = 0; req_addr = 32'h10; req_wdata = 32'h0;
        e = mk("b2b_b", 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 3, 0);
        e.ref_kind = 1;
        q.push_back(e);
        @(negedge clk);
        chk("b2b_busy_in_idle", {31'h0, busy}, 32'h0);
        outstanding = 1;
        @(negedge clk);
        req_valid = 0;

        // Reset while a sub-word store is in WR
        issue(1, 2'b10, 0, 32'h30, 32'h55667788, mk("sw30", 0, 0, 0, 0, 2, 1));
        wait_idle();
        req_valid = 1; req_we = 1; req_size = 2'b00; req_addr = 32'h31; req_wdata = 32'h000000CC;
        @(negedge clk);
        req_valid = 0;
        n = 0;
        while (!W && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("rst_wr_timeout", 32'h1, 32'h0);
        rst = 1;
        @(negedge clk);
        chk("abort_W", {31'h0, W}, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        rst = 0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", {31'h0, done}, 32'h0);
        end
        // The abort edge may or may not have committed the merged word
        issue(0, 2'b10, 0, 32'h30, 32'h0, mk("lw30_after_abort", 0, 1, 32'h55667788, 32'h5566CC88, 2, 0));
        issue(0, 2'b10, 0, 32'h24, 32'h0, mk("lw24_after_abort", 0, 1, 32'h80013344, 32'h80013344, 2, 0));

        wait_idle();
        chk("scoreboard_empty", q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- CPU-side load/store initiator that drives the single-port 128x32 data RAM (word address, level-sensitive write strobe, combinational read data).
- Accepts one load/store request at a time from the datapath.
- Performs word, halfword and byte accesses. Sub-word stores use a read-modify-write sequence.
- Returns load data sign- or zero-extended, plus a completion pulse and an error flag.

Parameters:
- AW, 7, RAM word-address width (128 words).
- BASE_CHECK, 1, when 1, a request with req_addr[31:AW+2] non-zero is flagged as an error.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request strobe; sampled only in IDLE
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=halfword, 10=word, 11=reserved
- req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- busy  out  1  high from accept until done
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: misaligned / reserved size / out of range
- rdata  out  32  load result, valid with done, held until next accept
- Addr  out  AW  RAM word address = req_addr[AW+1:2]
- W  out  1  RAM write strobe
- R  out  1  RAM read strobe (informational)
- W_data  out  32  RAM write data

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE; busy, done, err, W, R = 0; rdata, Addr, W_data = 0. Reset mid-access aborts at that edge. W drops immediately; the aborted request is not completed.
- Output registration: Addr, W, R and W_data are registered. Addr is latched at accept and is constant until the next accept. W is never high in a cycle where Addr or W_data changes.
- States: IDLE, RD, RMW_RD, WR, FIN.
- IDLE:
  - If req_valid=1, latch the request, set busy=1, and pick the next state: error -> FIN with err=1; load -> RD; word store -> WR; byte/half store -> RMW_RD.
  - req_valid while busy is ignored; there is no queueing.
- Error conditions:
  - req_size=11.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=00.
  - BASE_CHECK=1 and upper address bits non-zero.
  - On error, W stays 0 for the whole request, rdata=0, err=1.
- RD: R=1. Capture R_data at the clock edge, extract and extend it, -> FIN.
- RMW_RD: R=1. Capture R_data and merge store data into the selected lane(s), -> WR.
- WR: W=1 for exactly one cycle, W_data = full word or merged word, -> FIN.
- FIN: done=1 for one cycle, busy=0 at the same edge. -> IDLE. A new request is accepted only from IDLE (the cycle after done).
- Lane mapping (little-endian):
  - Byte n (n = addr[1:0]) occupies bits [8n+7:8n].
  - Halfword addr[1]=0 occupies [15:0]; addr[1]=1 occupies [31:16].
- Extension: sign extension copies bit 7 (byte) or bit 15 (halfword). Word loads ignore req_unsigned.
- Latency from the accept edge to done high:
  - Load and word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- err and rdata hold their values after done until the next accept. done is never high in two consecutive cycles.

Test Plan:
- Word store then load, addr 0x10, data 0xDEADBEEF -> W high exactly one cycle with Addr=4; load done 2 cycles after accept; rdata=0xDEADBEEF; err=0.
- Word 0x11223344 at 0x20, then sb 0xAA at 0x22 -> one RMW_RD cycle and one WR cycle; word becomes 0x11AA3344. Then lb 0x22 -> 0xFFFFFFAA; lbu 0x22 -> 0x000000AA.
- sh 0x8001 at 0x26 over 0x11AA3344 -> word 0x80013344. lh 0x26 -> 0xFFFF8001; lhu 0x26 -> 0x00008001; lh 0x24 -> 0x00003344.
- lw 0x21, lh 0x23, size=11, and addr 0x200 -> each gives done with err=1, rdata=0, W never asserted, 1-cycle latency.
- req_valid held high continuously across back-to-back requests -> second request accepted only in the IDLE cycle after done; intermediate req changes have no effect; busy low only in IDLE.
- rst asserted in the cycle a sub-word store is in WR -> next edge W=0, busy=0, no done pulse; a following lw returns consistent data with no partial corruption beyond the aborted word.
